// File: rtl/test_seq_module.sv
// test_seq_module: valid/ready elastic pipeline of DEPTH stages carrying four
// bitwise lane results (G17..G20) per beat.
// Optional feature macro: TEST_SEQ_ACC_EN
//   defined   -> G21 keeps a running XOR of every emitted G20,
//                G22 counts output handshakes (wraps modulo 2^CNT_W).
//   undefined -> G21 and G22 are tied to zero and their registers do not exist.
module test_seq_module #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     G1,
    input  logic [WIDTH-1:0]     G2,
    input  logic [WIDTH-1:0]     G3,
    input  logic [WIDTH-1:0]     G4,
    input  logic [2*WIDTH-1:0]   G5,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     G17,
    output logic [WIDTH-1:0]     G18,
    output logic [WIDTH-1:0]     G19,
    output logic [WIDTH-1:0]     G20,
    output logic [WIDTH-1:0]     G21,
    output logic [CNT_W-1:0]     G22
);

    localparam int DW = 4 * WIDTH;

    // Lane results computed from the raw inputs before stage 0
    logic [WIDTH-1:0] f17;
    logic [WIDTH-1:0] f18;
    logic [WIDTH-1:0] f19;
    logic [WIDTH-1:0] f20;
    logic [DW-1:0]    beat_in;

    // Per-stage views of the pipeline state and handshake terms
    logic [DEPTH-1:0] stage_valid;
    logic [DW-1:0]    stage_data [DEPTH];
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] advance;
    logic [DEPTH-1:0] fill_valid;
    logic [DW-1:0]    fill_data [DEPTH];
    logic             accept;

    genvar gi;

    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            assign f17[gi] = ~(G1[gi] & G3[gi]);
            assign f18[gi] = G2[gi] & G5[2*gi];
            assign f19[gi] = G5[2*gi+1] ^ G4[gi];
            assign f20[gi] = G1[gi] & G2[gi] & (G3[gi] ^ G4[gi]);
        end
    endgenerate

    assign beat_in = {f20, f19, f18, f17};

    // Stage k can take new contents when any stage from k to the end is empty
    // or the output is being drained. Written in closed form so there is no
    // combinational chain through the load vector; the only long path is
    // out_ready -> in_ready, which is intended.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_ctrl
            assign load[gi] = out_ready | ~(&stage_valid[DEPTH-1:gi]);
            if (gi == DEPTH - 1) begin : g_last
                assign advance[gi] = stage_valid[gi] & out_ready;
            end else begin : g_mid
                assign advance[gi] = stage_valid[gi] & load[gi+1];
            end
            if (gi == 0) begin : g_src_in
                assign fill_valid[gi] = accept;
                assign fill_data[gi]  = beat_in;
            end else begin : g_src_prev
                assign fill_valid[gi] = advance[gi-1];
                assign fill_data[gi]  = stage_data[gi-1];
            end
        end
    endgenerate

    assign in_ready  = ~rst & load[0];
    assign accept    = in_valid & in_ready;
    assign out_valid = stage_valid[DEPTH-1];
    assign {G20, G19, G18, G17} = stage_data[DEPTH-1];

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic          valid_reg;
            logic [DW-1:0] data_reg;

            // Stage register: refill whenever the slot is free or moving on;
            // data only changes when a real beat arrives
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (load[gi]) begin
                    valid_reg <= fill_valid[gi];
                    if (fill_valid[gi]) begin
                        data_reg <= fill_data[gi];
                    end
                end
            end

            assign stage_valid[gi] = valid_reg;
            assign stage_data[gi]  = data_reg;
        end
    endgenerate

`ifdef TEST_SEQ_ACC_EN
    logic             emit;
    logic [WIDTH-1:0] acc_reg;
    logic [CNT_W-1:0] cnt_reg;

    assign emit = out_valid & out_ready;

    // Fold each emitted G20 into the XOR accumulator and count the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (emit) begin
            acc_reg <= acc_reg ^ G20;
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign G21 = acc_reg;
    assign G22 = cnt_reg;
`else
    assign G21 = '0;
    assign G22 = '0;
`endif

endmodule

// File: tb/tb_test_seq_module.sv
// Scoreboard bench for test_seq_module (WIDTH=4, DEPTH=2, CNT_W=8).
// Accumulator expectations follow TEST_SEQ_ACC_EN exactly as the RTL sees it.
module tb_test_seq_module;

    localparam int W = 4;
    localparam int D = 2;
    localparam int C = 8;

    typedef logic [4*W-1:0] beat_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   g1 = '0, g2 = '0, g3 = '0, g4 = '0;
    logic [2*W-1:0] g5 = '0;
    logic           in_ready, out_valid;
    logic [W-1:0]   g17, g18, g19, g20, g21;
    logic [C-1:0]   g22;

    int    checks = 0;
    int    failures = 0;
    int    n_emit = 0;
    beat_t exp_q[$];
    logic [W-1:0] m_acc = '0;
    logic [C-1:0] m_cnt = '0;

    test_seq_module #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .G1(g1), .G2(g2), .G3(g3), .G4(g4), .G5(g5),
        .out_valid(out_valid), .out_ready(out_ready),
        .G17(g17), .G18(g18), .G19(g19), .G20(g20), .G21(g21), .G22(g22)
    );

    always #5 clk = ~clk;

    // Reference: lane equations straight from the requirement text
    function automatic beat_t model(input logic [W-1:0] a, b, c, d, input logic [2*W-1:0] e);
        logic [W-1:0] ev, od;
        for (int i = 0; i < W; i++) begin
            ev[i] = e[2*i];
            od[i] = e[2*i+1];
        end
        return {a & b & (c ^ d), od ^ d, b & ev, ~(a & c)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic rand_data();
        g1 = W'($urandom); g2 = W'($urandom); g3 = W'($urandom); g4 = W'($urandom);
        g5 = (2*W)'($urandom);
    endtask

    // One clock: note an accept at the coming edge, then settle after it
    task automatic step(output bit a);
        @(negedge clk);
        a = !rst && in_valid && in_ready;
        if (a) begin
            exp_q.push_back(model(g1, g2, g3, g4, g5));
            $display("accept beat=%h", model(g1, g2, g3, g4, g5));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bit a;
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        rand_data();
        for (int i = 0; i < 2; i++) begin
            step(a);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_outs", {g17, g18, g19, g20, g21, g22}, 0);
        end
        exp_q.delete();
        m_acc = '0;
        m_cnt = '0;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("in_ready_after_rst", in_ready, 1);
    endtask

    // Monitor: pops the scoreboard on each emit, checks stalls and G21/G22
    initial begin
        bit    prev_stall = 0;
        beat_t prev_beat = '0;
        beat_t cur, e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                cur = {g20, g19, g18, g17};
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", cur, prev_beat);
                end
`ifdef TEST_SEQ_ACC_EN
                chk("g21_run", g21, m_acc);
                chk("g22_run", g22, m_cnt);
`else
                chk("g21_tied", g21, 0);
                chk("g22_tied", g22, 0);
`endif
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_emit actual=%h required=none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        chk("emit_data", cur, e);
                        $display("emit beat=%h expected=%h", cur, e);
                        m_acc = m_acc ^ e[4*W-1:3*W];
                        m_cnt = m_cnt + 1'b1;
                    end
                    n_emit++;
                end
                prev_stall = out_valid && !out_ready;
                prev_beat  = cur;
            end
        end
    end

    initial begin
        bit a;
        int nacc, base, cyc;

        // Reset behaviour
        do_reset();

        // Single directed beat
        g1 = 4'hF; g2 = 4'hF; g3 = 4'h5; g4 = 4'h0; g5 = 8'h00;
        in_valid = 1'b1; out_ready = 1'b1;
        step(a);
        chk("one_accept", a, 1);
        in_valid = 1'b0;
        step(a);
        chk("one_valid", out_valid, 1);
        chk("one_g17", g17, 4'hA);
        chk("one_g18", g18, 4'h0);
        chk("one_g19", g19, 4'h0);
        chk("one_g20", g20, 4'h5);
        step(a);
`ifdef TEST_SEQ_ACC_EN
        chk("one_g21", g21, 4'h5);
        chk("one_g22", g22, 8'h01);
`else
        chk("one_g21", g21, 0);
        chk("one_g22", g22, 0);
`endif

        // Backpressure: fill, then drain five beats one per cycle
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; nacc = 0;
        rand_data();
        for (int i = 0; i < 4; i++) begin
            step(a);
            if (a) begin nacc++; rand_data(); end
        end
        chk("full_accepts", nacc, D);
        chk("full_in_ready", in_ready, 0);
        out_ready = 1'b1;
        base = n_emit;
        for (int i = 0; i < 5; i++) begin
            step(a);
            if (a) begin nacc++; rand_data(); end
            if (nacc >= 5) in_valid = 1'b0;
        end
        chk("drain_emits", n_emit - base, 5);
        chk("drain_accepts", nacc, 5);
        chk("drain_empty_valid", out_valid, 0);
`ifdef TEST_SEQ_ACC_EN
        chk("drain_g22", g22, 8'd5);
`endif

        // 256 emits: counter wraps, accumulator is XOR of all G20
        do_reset();
        base = n_emit; cyc = 0;
        while ((n_emit - base) < 256 && cyc < 5000) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            rand_data();
            step(a);
            cyc++;
        end
        out_ready = 1'b0; in_valid = 1'b0;
        chk("wrap_emit_count", n_emit - base, 256);
`ifdef TEST_SEQ_ACC_EN
        chk("wrap_g22", g22, 8'h00);
        chk("wrap_g21", g21, m_acc);
`else
        chk("wrap_g22", g22, 0);
        chk("wrap_g21", g21, 0);
`endif

        // Reset with two beats in flight discards them
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rand_data();
            step(a);
        end
        do_reset();
        chk("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        base = n_emit;
        for (int i = 0; i < 10; i++) step(a);
        chk("flush_no_emit", n_emit - base, 0);
        chk("flush_g21_g22", {g21, g22}, 0);

        // Random soak then drain
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom % 3) != 0;
            out_ready = ($urandom % 3) != 0;
            rand_data();
            step(a);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            step(a);
            cyc++;
        end
        chk("soak_drained", exp_q.size(), 0);
        chk("soak_out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
